nlprg_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one free-running `nlprg11` 11-bit non-linear PRNG between R requesters. Every cycle it hands the current PRNG word to at most one requester, so no two requesters ever receive the same word within a period. It also runs the period-lock health monitor in hardware: the generator must return to state 0 exactly when an 11-bit cycle counter wraps. On a violation the block stops granting and raises a sticky fault.

---
 rtl/nlprg_pkg.sv | 16 +
 rtl/nlprg11.sv | 36 +++
 rtl/nlprg_arb.sv | 123 ++++++++++++
 tb/tb_nlprg_arb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/nlprg_pkg.sv
// Shared constants and types for the nlprg11 arbiter slice.
package nlprg_pkg;

    localparam int NLPRG_W = 11;
    localparam int NLPRG_R = 4;

    // Number of warm-up edges minus one, counted by the 2-bit arm delay.
    localparam logic [1:0] ARM_LAST = 2'd1;

    typedef enum logic [1:0] {
        WARM  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/nlprg11.sv
// 11-bit non-linear PRNG: maximal LFSR (x^11 + x^2 + 1) with the all-zero state
// spliced in, giving a single 2048-state cycle that starts at 0 out of reset.
module nlprg11
    import nlprg_pkg::*;
(
    input  logic               ck,
    input  logic               rst,
    output logic [NLPRG_W-1:0] o
);

    logic [NLPRG_W-1:0] state_reg;
    logic [NLPRG_W-1:0] state_next;
    logic               fb;

    // The zero-detect term detours 100..0 through 00..0 before 00..01.
    assign fb = state_reg[10] ^ state_reg[8] ^ (state_reg[9:0] == 10'd0);
    assign state_next[0] = fb;

    genvar gi;
    generate
        for (gi = 1; gi < NLPRG_W; gi++) begin : g_shift
            assign state_next[gi] = state_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_reg <= '0;
        end else begin
            state_reg <= state_next;
        end
    end

    assign o = state_reg;

endmodule

// File: rtl/nlprg_arb.sv
// Round-robin arbiter handing out one nlprg11 word per cycle, with a hardware
// period-lock monitor that stops grants on any generator/counter phase slip.
module nlprg_arb
    import nlprg_pkg::*;
#(
    parameter int N = NLPRG_W,
    parameter int R = NLPRG_R
) (
    input  logic         ck,
    input  logic         rst_n,
    input  logic [R-1:0] req,
    output logic [R-1:0] gnt,
    output logic [N-1:0] dout,
    output logic         ready,
    output logic         wrap,
    output logic         fault
);

    localparam int PW = $clog2(R);

    logic [N-1:0]  prn;
    logic [N-1:0]  cnt_reg;
    logic [1:0]    arm_reg;
    logic [PW-1:0] ptr_reg;
    arb_state_e    state_reg;
    logic [R-1:0]  gnt_reg;
    logic [N-1:0]  dout_reg;
    logic          ready_reg;
    logic          wrap_reg;
    logic          fault_reg;

    logic [PW:0]   pick;
    logic          pick_ok;
    logic [PW-1:0] pick_idx;
    logic          prn_zero;
    logic          cnt_zero;

    nlprg11 u_nlprg (
        .ck  (ck),
        .rst (~rst_n),
        .o   (prn)
    );

    // Rotate so ptr+1 sits at bit 0, take the lowest set bit, rotate back.
    // Returns {found, index}.
    function automatic logic [PW:0] rr_pick(input logic [R-1:0] r, input logic [PW-1:0] p);
        logic [2*R-1:0] dbl;
        logic [R-1:0]   rot;
        int             sh;
        int             k;
        dbl = {r, r};
        sh  = int'(p) + 1;
        rot = R'(dbl >> sh);
        k   = -1;
        for (int i = R - 1; i >= 0; i--) begin
            if (rot[i]) k = i;
        end
        if (k < 0) return '0;
        return {1'b1, PW'((sh + k) % R)};
    endfunction

    assign pick     = rr_pick(req, ptr_reg);
    assign pick_ok  = pick[PW];
    assign pick_idx = pick[PW-1:0];
    assign prn_zero = (prn == '0);
    assign cnt_zero = (cnt_reg == '0);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= WARM;
            arm_reg   <= '0;
            cnt_reg   <= '0;
            ptr_reg   <= PW'(R - 1);
            gnt_reg   <= '0;
            dout_reg  <= '0;
            ready_reg <= 1'b0;
            wrap_reg  <= 1'b0;
            fault_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_reg + N'(1);
            gnt_reg  <= '0;
            wrap_reg <= 1'b0;
            case (state_reg)
                WARM: begin
                    arm_reg <= arm_reg + 2'd1;
                    if (arm_reg == ARM_LAST) begin
                        state_reg <= RUN;
                        ready_reg <= 1'b1;
                    end
                end
                RUN: begin
                    // A phase slip kills the grant that would have gone out on this edge.
                    if (prn_zero != cnt_zero) begin
                        state_reg <= FAULT;
                        fault_reg <= 1'b1;
                        ready_reg <= 1'b0;
                    end else begin
                        wrap_reg <= prn_zero;
                        if (pick_ok) begin
                            gnt_reg  <= R'(1) << pick_idx;
                            dout_reg <= prn;
                            ptr_reg  <= pick_idx;
                        end
                    end
                end
                FAULT: begin
                end
                default: begin
                    state_reg <= FAULT;
                    fault_reg <= 1'b1;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = gnt_reg;
    assign dout  = dout_reg;
    assign ready = ready_reg;
    assign wrap  = wrap_reg;
    assign fault = fault_reg;

endmodule

// File: tb/tb_nlprg_arb.sv
// Directed bench for nlprg_arb: table-driven arbitration vectors plus sequences
// for full-period output, wrap timing, fault injection and reset mid-grant.
module tb_nlprg_arb;
    import nlprg_pkg::*;

    localparam int R = 4;
    localparam int N = NLPRG_W;
    localparam int P = 2048;

    logic         ck    = 1'b0;
    logic         rst_n = 1'b0;
    logic [R-1:0] req   = '0;
    logic [R-1:0] gnt;
    logic [N-1:0] dout;
    logic         ready;
    logic         wrap;
    logic         fault;

    nlprg_arb #(.N(N), .R(R)) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .dout  (dout),
        .ready (ready),
        .wrap  (wrap),
        .fault (fault)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [R-1:0] req;
        logic [R-1:0] gnt;
        logic         ready;
    } vec_t;

    vec_t         vecs[16];
    logic [N-1:0] seq[P];
    bit           seen[P];
    int           tests_run    = 0;
    int           tests_failed = 0;
    int           ed           = 0;
    int           wraps        = 0;
    logic [N-1:0] exp_dout     = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, ed);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        ed++;
        #1;
    endtask

    task automatic chk_gnt(input logic [R-1:0] g_exp);
        chk("gnt", 32'(gnt), 32'(g_exp));
        if (g_exp != '0) exp_dout = seq[(ed - 1) % P];
        chk("dout", 32'(dout), 32'(exp_dout));
    endtask

    task automatic chk_mon(input logic fault_exp);
        logic w_exp;
        w_exp = !fault_exp && (ed >= 3) && (((ed - 1) % P) == 0);
        chk("wrap", 32'(wrap), 32'(w_exp));
        chk("fault", 32'(fault), 32'(fault_exp));
        if (wrap) wraps++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   32'(gnt),   32'd0);
        chk({tag, "_dout"},  32'(dout),  32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_wrap"},  32'(wrap),  32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    // Release reset and walk the warm-up into the first two contended grants.
    task automatic warm_seq(input string tag);
        logic [R-1:0] g_exp[4];
        logic         r_exp[4];
        g_exp = '{4'b0000, 4'b0000, 4'b0001, 4'b0010};
        r_exp = '{1'b0, 1'b1, 1'b1, 1'b1};
        rst_n    = 1'b1;
        ed       = 0;
        exp_dout = '0;
        req      = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_gnt(g_exp[i]);
            chk({tag, "_ready"}, 32'(ready), 32'(r_exp[i]));
            chk_mon(1'b0);
            $display("[TB] %s edge %0d gnt=%b dout=%h ready=%b", tag, ed, gnt, dout, ready);
        end
    endtask

    initial begin
        logic [N-1:0] s;
        logic         fb;
        int           distinct;

        s = '0;
        for (int k = 0; k < P; k++) begin
            seq[k] = s;
            fb = s[10] ^ s[8] ^ (s[9:0] == 10'd0);
            s  = {s[9:0], fb};
        end

        vecs[0]  = '{4'b1111, 4'b0000, 1'b0};
        vecs[1]  = '{4'b1111, 4'b0000, 1'b1};
        vecs[2]  = '{4'b1111, 4'b0001, 1'b1};
        vecs[3]  = '{4'b1111, 4'b0010, 1'b1};
        vecs[4]  = '{4'b1111, 4'b0100, 1'b1};
        vecs[5]  = '{4'b1111, 4'b1000, 1'b1};
        vecs[6]  = '{4'b1111, 4'b0001, 1'b1};
        vecs[7]  = '{4'b0000, 4'b0000, 1'b1};
        vecs[8]  = '{4'b1010, 4'b0010, 1'b1};
        vecs[9]  = '{4'b1010, 4'b1000, 1'b1};
        vecs[10] = '{4'b0101, 4'b0001, 1'b1};
        vecs[11] = '{4'b0001, 4'b0001, 1'b1};
        vecs[12] = '{4'b1100, 4'b0100, 1'b1};
        vecs[13] = '{4'b0100, 4'b0100, 1'b1};
        vecs[14] = '{4'b0011, 4'b0001, 1'b1};
        vecs[15] = '{4'b0000, 4'b0000, 1'b1};

        // Reset held for three edges with every requester asking.
        rst_n = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all_zero("reset");
        end
        rst_n    = 1'b1;
        ed       = 0;
        exp_dout = '0;

        for (int i = 0; i < 16; i++) begin
            req = vecs[i].req;
            tick();
            chk_gnt(vecs[i].gnt);
            chk("ready", 32'(ready), 32'(vecs[i].ready));
            chk_mon(1'b0);
            $display("[TB] vec %0d edge %0d req=%b gnt=%b dout=%h ready=%b", i, ed, req, gnt, dout, ready);
        end

        // One requester for a full period: every word once, including 0.
        req = 4'b0100;
        for (int i = 0; i < P; i++) begin
            tick();
            chk_gnt(4'b0100);
            chk_mon(1'b0);
            seen[dout] = 1'b1;
        end
        distinct = 0;
        for (int i = 0; i < P; i++) if (seen[i]) distinct++;
        chk("distinct_words", 32'(distinct), 32'(P));
        $display("[TB] single requester: %0d distinct words over %0d grants", distinct, P);

        req = '0;
        while (ed < 3 * P + 100) begin
            tick();
            chk_gnt(4'b0000);
            chk_mon(1'b0);
        end
        chk("wrap_count", 32'(wraps), 32'd3);
        $display("[TB] period monitor: %0d wrap pulses by edge %0d", wraps, ed);

        // Counter now reads 100: a zero word here is a phase slip.
        req = 4'b1111;
        force dut.prn = '0;
        tick();
        release dut.prn;
        chk("fault_set", 32'(fault), 32'd1);
        chk("fault_ready", 32'(ready), 32'd0);
        chk("fault_gnt", 32'(gnt), 32'd0);
        $display("[TB] fault injected: fault=%b ready=%b gnt=%b", fault, ready, gnt);
        while (ed < 4 * P + 10) begin
            tick();
            chk_gnt(4'b0000);
            chk("fault_ready", 32'(ready), 32'd0);
            chk_mon(1'b1);
        end

        rst_n = 1'b0;
        #1;
        chk_all_zero("fault_clear");
        tick();
        tick();
        warm_seq("restart");

        // gnt[1] is high right now; reset must drop it without a clock.
        chk("pre_reset_gnt", 32'(gnt), 32'b0010);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_grant");
        $display("[TB] reset mid-grant: gnt=%b dout=%h fault=%b", gnt, dout, fault);
        tick();
        tick();
        warm_seq("rewarm");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
